// File: rtl/vram_pattern.sv
// Dual-port video RAM that paints a band/stripe test image into itself after reset
// or reinit, then serves pipelined pixel reads and single-cycle pixel writes.
module vram_pattern #(
   parameter int ADDR_W = 14,
   parameter int ROW_W  = 7,
   parameter int CW     = 1,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] address,
   output logic [CW-1:0]     red_output,
   output logic [CW-1:0]     green_output,
   output logic [CW-1:0]     blue_output,
   output logic              valid_out,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3*CW-1:0]   wr_data,
   input  logic              reinit,
   output logic              ready
);

   localparam int DW = 3 * CW;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [CW-1:0] FULL = '1;
   localparam logic [CW-1:0] OFF  = '0;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] counter;
   logic [ADDR_W-1:0] next_counter;
   logic              fill_we;
   logic              user_we;
   logic              rd_fire;
   logic [DW-1:0]     rd_data1;
   logic              valid1;
   logic [DW-1:0]     out_data;

   logic [DW-1:0] mem [2**ADDR_W];

   // Border column wins over everything; otherwise the top band selects the colour.
   function automatic logic [DW-1:0] pattern(input logic [ADDR_W-1:0] a);
      logic [1:0]    band;
      logic [2:0]    s;
      logic [DW-1:0] pix;
      band = a[ADDR_W-1 -: 2];
      s    = a[2:0];
      pix  = {FULL, FULL, FULL};
      if (!(&a[ROW_W-1:0])) begin
         case (band)
            2'b11: pix = {FULL, OFF, OFF};
            2'b10: pix = {OFF, FULL, OFF};
            2'b01: pix = {OFF, OFF, FULL};
            default: begin
               case (s)
                  3'd6, 3'd5: pix = {FULL, OFF, OFF};
                  3'd4, 3'd3: pix = {OFF, FULL, OFF};
                  3'd2, 3'd1: pix = {OFF, OFF, FULL};
                  default:    pix = {FULL, FULL, FULL};
               endcase
            end
         endcase
      end
      return pix;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= INIT;
         counter <= '0;
      end else begin
         state   <= next_state;
         counter <= next_counter;
      end
   end

   // The counter parks on the last address in RUN instead of overflowing.
   always_comb begin
      next_state   = state;
      next_counter = counter;
      fill_we      = 1'b0;
      case (state)
         INIT: begin
            fill_we = 1'b1;
            if (counter == LAST_ADDR) begin
               next_state = RUN;
            end else begin
               next_counter = counter + 1'b1;
            end
         end
         RUN: begin
            if (reinit) begin
               next_state   = INIT;
               next_counter = '0;
            end
         end
         default: begin
            next_state   = INIT;
            next_counter = '0;
         end
      endcase
   end

   assign ready   = (state == RUN);
   assign rd_fire = en & ready;
   assign user_we = wr_en & ready & ~reinit;

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[counter] <= pattern(counter);
      end else if (user_we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-first: the registered read sees the word as it was before this edge's write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data1 <= '0;
         valid1   <= 1'b0;
      end else begin
         valid1 <= rd_fire;
         if (rd_fire) begin
            rd_data1 <= mem[address];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DW-1:0] rd_data2;
         logic          valid2;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rd_data2 <= '0;
               valid2   <= 1'b0;
            end else begin
               valid2 <= valid1;
               if (valid1) begin
                  rd_data2 <= rd_data1;
               end
            end
         end

         assign out_data  = rd_data2;
         assign valid_out = valid2;
      end else begin : g_lat1
         assign out_data  = rd_data1;
         assign valid_out = valid1;
      end
   endgenerate

   assign red_output   = out_data[DW-1 -: CW];
   assign green_output = out_data[2*CW-1 -: CW];
   assign blue_output  = out_data[CW-1:0];

endmodule

// File: tb/tb_vram_pattern.sv
// Directed bench for vram_pattern: three instances cover the default build,
// a 4-bit colour build, and the two-cycle read latency build.
module tb_vram_pattern;

   logic clk;
   logic reset;

   logic        en_a, wr_en_a, reinit_a, ready_a, valid_a;
   logic [13:0] address_a, wr_addr_a;
   logic [2:0]  wr_data_a;
   logic        red_a, green_a, blue_a;

   logic        en_b, wr_en_b, reinit_b, ready_b, valid_b;
   logic [13:0] address_b, wr_addr_b;
   logic [11:0] wr_data_b;
   logic [3:0]  red_b, green_b, blue_b;

   logic        en_c, wr_en_c, reinit_c, ready_c, valid_c;
   logic [13:0] address_c, wr_addr_c;
   logic [2:0]  wr_data_c;
   logic        red_c, green_c, blue_c;

   int compared;
   int mismatched;

   typedef struct {
      logic [13:0] addr;
      logic [2:0]  rgb;
   } pat_vec_t;

   pat_vec_t vec [14];
   pat_vec_t lat_vec [4];

   vram_pattern dut_a (
      .clk(clk), .reset(reset), .en(en_a), .address(address_a),
      .red_output(red_a), .green_output(green_a), .blue_output(blue_a),
      .valid_out(valid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
      .wr_data(wr_data_a), .reinit(reinit_a), .ready(ready_a)
   );

   vram_pattern #(.CW(4)) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .address(address_b),
      .red_output(red_b), .green_output(green_b), .blue_output(blue_b),
      .valid_out(valid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
      .wr_data(wr_data_b), .reinit(reinit_b), .ready(ready_b)
   );

   vram_pattern #(.RD_LAT(2)) dut_c (
      .clk(clk), .reset(reset), .en(en_c), .address(address_c),
      .red_output(red_c), .green_output(green_c), .blue_output(blue_c),
      .valid_out(valid_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
      .wr_data(wr_data_c), .reinit(reinit_c), .ready(ready_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Runs a full fill on the selected instance and checks ready stays low until the last edge.
   task automatic wait_fill(input int which, input string tag);
      logic rdy;
      for (int i = 1; i <= 16384; i++) begin
         tick();
         rdy = (which == 0) ? ready_a : (which == 1) ? ready_b : ready_c;
         if (i == 16383) check_output({tag, " ready low at 16383"}, rdy, 0);
         if (i == 16384) check_output({tag, " ready high at 16384"}, rdy, 1);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset = 1'b0;
      en_a = 0; wr_en_a = 0; reinit_a = 0; address_a = '0; wr_addr_a = '0; wr_data_a = '0;
      en_b = 0; wr_en_b = 0; reinit_b = 0; address_b = '0; wr_addr_b = '0; wr_data_b = '0;
      en_c = 0; wr_en_c = 0; reinit_c = 0; address_c = '0; wr_addr_c = '0; wr_data_c = '0;

      vec[0]  = '{14'h2FFF, 3'b111};
      vec[1]  = '{14'h3F00, 3'b100};
      vec[2]  = '{14'h2F00, 3'b010};
      vec[3]  = '{14'h2300, 3'b010};
      vec[4]  = '{14'h1700, 3'b001};
      vec[5]  = '{14'h1FFF, 3'b111};
      vec[6]  = '{14'h0B7E, 3'b100};
      vec[7]  = '{14'h0B7D, 3'b100};
      vec[8]  = '{14'h0B7C, 3'b010};
      vec[9]  = '{14'h0B7B, 3'b010};
      vec[10] = '{14'h0B7A, 3'b001};
      vec[11] = '{14'h0B79, 3'b001};
      vec[12] = '{14'h0B07, 3'b111};
      vec[13] = '{14'h0B78, 3'b111};

      lat_vec[0] = '{14'h0B7E, 3'b100};
      lat_vec[1] = '{14'h2300, 3'b010};
      lat_vec[2] = '{14'h1700, 3'b001};
      lat_vec[3] = '{14'h0B78, 3'b111};

      repeat (3) tick();
      check_output("reset ready_a", ready_a, 0);
      check_output("reset valid_a", valid_a, 0);
      check_output("reset rgb_a", {red_a, green_a, blue_a}, 0);
      check_output("reset ready_b", ready_b, 0);
      check_output("reset rgb_b", {red_b, green_b, blue_b}, 0);
      check_output("reset valid_c", valid_c, 0);

      // Release reset mid-cycle so the next rising edge writes fill address 0.
      reset = 1'b1;
      for (int i = 1; i <= 16384; i++) begin
         if (i == 100) begin
            en_a = 1'b1;
            address_a = 14'h0B7E;
         end
         tick();
         if (i == 100) begin
            check_output("init read valid_a", valid_a, 0);
            check_output("init read rgb_a", {red_a, green_a, blue_a}, 0);
            en_a = 1'b0;
         end
         if (i == 16383) begin
            check_output("fill ready_a low at 16383", ready_a, 0);
            check_output("fill ready_b low at 16383", ready_b, 0);
            check_output("fill ready_c low at 16383", ready_c, 0);
         end
      end
      check_output("fill ready_a at 16384", ready_a, 1);
      check_output("fill ready_b at 16384", ready_b, 1);
      check_output("fill ready_c at 16384", ready_c, 1);

      for (int i = 0; i < 14; i++) begin
         en_a = 1'b1;
         address_a = vec[i].addr;
         tick();
         check_output($sformatf("pattern valid %h", vec[i].addr), valid_a, 1);
         check_output($sformatf("pattern rgb %h", vec[i].addr), {red_a, green_a, blue_a}, vec[i].rgb);
      end
      en_a = 1'b0;
      address_a = 14'h3F00;
      tick();
      check_output("idle valid_a", valid_a, 0);
      check_output("idle hold rgb_a", {red_a, green_a, blue_a}, 3'b111);

      en_b = 1'b1; address_b = 14'h0123;
      wr_en_b = 1'b1; wr_addr_b = 14'h0123; wr_data_b = 12'hA5C;
      tick();
      check_output("rd-first valid_b", valid_b, 1);
      check_output("rd-first old rgb_b", {red_b, green_b, blue_b}, 12'h0F0);
      wr_en_b = 1'b0;
      tick();
      check_output("after write red_b", red_b, 4'hA);
      check_output("after write green_b", green_b, 4'h5);
      check_output("after write blue_b", blue_b, 4'hC);
      en_b = 1'b0;

      for (int i = 0; i < 6; i++) begin
         en_c = (i < 4);
         address_c = lat_vec[(i < 4) ? i : 3].addr;
         tick();
         if (i == 0) begin
            check_output("lat2 first edge valid_c", valid_c, 0);
         end else if (i <= 4) begin
            check_output($sformatf("lat2 valid_c %0d", i), valid_c, 1);
            check_output($sformatf("lat2 rgb_c %0d", i), {red_c, green_c, blue_c}, lat_vec[i-1].rgb);
         end else begin
            check_output("lat2 drain valid_c", valid_c, 0);
            check_output("lat2 hold rgb_c", {red_c, green_c, blue_c}, lat_vec[3].rgb);
         end
      end
      en_c = 1'b0;

      // reinit with a read and a write in the same cycle.
      reinit_b = 1'b1; en_b = 1'b1; address_b = 14'h0040;
      wr_en_b = 1'b1; wr_addr_b = 14'h0040; wr_data_b = 12'h123;
      tick();
      reinit_b = 1'b0; en_b = 1'b0; wr_en_b = 1'b0;
      check_output("reinit ready_b falls", ready_b, 0);
      check_output("reinit read valid_b", valid_b, 1);
      check_output("reinit read rgb_b", {red_b, green_b, blue_b}, 12'hFFF);
      wait_fill(1, "refill b");
      en_b = 1'b1; address_b = 14'h0123;
      tick();
      check_output("refill restores 0123", {red_b, green_b, blue_b}, 12'h0F0);
      en_b = 1'b0;

      reinit_a = 1'b1;
      tick();
      reinit_a = 1'b0;
      check_output("reinit ready_a falls", ready_a, 0);
      repeat (5000) tick();
      #2;
      reset = 1'b0;
      #1;
      check_output("async reset ready_a", ready_a, 0);
      check_output("async reset rgb_a", {red_a, green_a, blue_a}, 0);
      check_output("async reset rgb_b", {red_b, green_b, blue_b}, 0);
      check_output("async reset ready_c", ready_c, 0);
      tick();
      reset = 1'b1;
      wait_fill(0, "restart a");
      en_a = 1'b1; address_a = 14'h0B7E;
      tick();
      check_output("post-restart rgb_a", {red_a, green_a, blue_a}, 3'b100);
      en_a = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
